cond_eval_unit: RTL

- Registered, handshaked successor to the combinational branch-condition checker.
- Holds the architectural flag register in {Z,C,N,V} order and applies masked flag writes from the ALU.
- Evaluates all 16 ARM condition codes for each instruction and tracks Thumb-2 IT-block state, so instructions inside an IT block take their condition from ITSTATE.
- Sits between decode and execute/branch, and produces the per-instruction pass/fail decision with a tag.

---
 rtl/cond_eval_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cond_eval_unit.sv
// cond_eval_unit
//   Registered condition evaluator sitting between decode and execute/branch.
//   Keeps the architectural {Z,C,N,V} flag register (masked ALU writes),
//   evaluates the 16 ARM condition codes and tracks Thumb-2 IT-block state so
//   instructions inside an IT block take their condition from ITSTATE.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flag_we/flag_mask/flags_in   masked flag write, order {Z,C,N,V}
//   flush             clears IT state and any pending result
//   in_valid/in_ready input handshake
//   in_cond           condition field used outside an IT block
//   in_is_it, in_it_firstcond, in_it_mask   IT instruction fields
//   in_tag            instruction tag carried to out_tag
//   out_valid/out_ready  output handshake
//   do_branch         condition passed
//   out_in_it         result produced under IT control
//   it_err            malformed or nested IT instruction
//   out_tag           tag of the result
//   flags_q           current flag register
module cond_eval_unit #(
  parameter bit FORWARD   = 1'b1,
  parameter bit NV_PASS   = 1'b1,
  parameter bit IT_ENABLE = 1'b1,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic [3:0]       flag_mask,
  input  logic [3:0]       flags_in,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic             in_is_it,
  input  logic [3:0]       in_it_firstcond,
  input  logic [3:0]       in_it_mask,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             do_branch,
  output logic             out_in_it,
  output logic             it_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags_q
);

  typedef enum logic {IDLE = 1'b0, IN_IT = 1'b1} it_state_e;

  logic [3:0]       flags_d;
  logic [7:0]       itstate_q, itstate_d;
  logic             out_valid_q, out_valid_d;
  logic             do_branch_q, do_branch_d;
  logic             out_in_it_q, out_in_it_d;
  logic             it_err_q, it_err_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [3:0]       flags_merged;
  logic [3:0]       eval_flags;
  logic [7:0]       itstate_adv;
  logic             is_it;
  logic             accept;
  it_state_e        it_state;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    logic r;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = c && !z;
      4'h9:    r = !c || z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = z || (n != v);
      4'hE:    r = 1'b1;
      default: r = NV_PASS;
    endcase
    return r;
  endfunction

  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign do_branch = do_branch_q;
  assign out_in_it = out_in_it_q;
  assign it_err    = it_err_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    flags_merged = (flags_q & ~flag_mask) | (flags_in & flag_mask);
    flags_d      = flag_we ? flags_merged : flags_q;
    // Forwarding lets an evaluation see a flag write landing on the same edge.
    eval_flags   = (FORWARD && flag_we) ? flags_merged : flags_q;

    it_state = (IT_ENABLE && (itstate_q[3:0] != 4'd0)) ? IN_IT : IDLE;
    is_it    = IT_ENABLE && in_is_it;
    accept   = in_valid && in_ready;

    // ITAdvance: the last instruction of the block leaves mask bits [2:0] zero.
    if (itstate_q[2:0] == 3'd0) itstate_adv = 8'd0;
    else                        itstate_adv = {itstate_q[7:5], itstate_q[3:0], 1'b0};

    itstate_d   = itstate_q;
    out_valid_d = out_valid_q;
    do_branch_d = do_branch_q;
    out_in_it_d = out_in_it_q;
    it_err_d    = it_err_q;
    out_tag_d   = out_tag_q;

    if (flush) begin
      itstate_d   = 8'd0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_tag_d   = in_tag;
      if (it_state == IN_IT) begin
        out_in_it_d = 1'b1;
        itstate_d   = itstate_adv;
        if (is_it) begin
          it_err_d    = 1'b1;
          do_branch_d = 1'b0;
        end else begin
          it_err_d    = 1'b0;
          do_branch_d = cond_pass(itstate_q[7:4], eval_flags);
        end
      end else if (is_it) begin
        out_in_it_d = 1'b0;
        if (in_it_mask != 4'd0) begin
          it_err_d    = 1'b0;
          do_branch_d = 1'b1;
          itstate_d   = {in_it_firstcond, in_it_mask};
        end else begin
          it_err_d    = 1'b1;
          do_branch_d = 1'b0;
        end
      end else begin
        out_in_it_d = 1'b0;
        it_err_d    = 1'b0;
        do_branch_d = cond_pass(in_cond, eval_flags);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= 4'd0;
      itstate_q   <= 8'd0;
      out_valid_q <= 1'b0;
      do_branch_q <= 1'b0;
      out_in_it_q <= 1'b0;
      it_err_q    <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      flags_q     <= flags_d;
      itstate_q   <= itstate_d;
      out_valid_q <= out_valid_d;
      do_branch_q <= do_branch_d;
      out_in_it_q <= out_in_it_d;
      it_err_q    <= it_err_d;
      out_tag_q   <= out_tag_d;
    end
  end

endmodule
